// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - op encodings, FSM states and negate helper for mult_div_unit
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_RESULT,
        S_DIVZERO
    } state_t;

    // Widest supported WIDTH; callers zero-extend into this and slice back down.
    localparam int MAX_W = 64;

    function automatic logic [2*MAX_W-1:0] twos_neg(input logic [2*MAX_W-1:0] v);
        return (~v) + {{(2*MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// rtl/mult_div_datapath.sv - shift-add multiply / restoring divide datapath with sign fixup
// Optional MULT_EARLY_TERM_EN: aligns the product in one step once the remaining multiplier bits are zero.
module mult_div_datapath
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] cnt,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    output logic             early,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        logic [2*MAX_W-1:0] t;
        t = '0;
        t[WIDTH-1:0] = v;
        t = twos_neg(t);
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_w2(input logic [2*WIDTH-1:0] v);
        logic [2*MAX_W-1:0] t;
        t = '0;
        t[2*WIDTH-1:0] = v;
        t = twos_neg(t);
        return t[2*WIDTH-1:0];
    endfunction

    logic [2*WIDTH-1:0] acc, acc_nx, prod_fix;
    logic [WIDTH-1:0]   m, hi_q, lo_q, hi_fix, lo_fix, abs_a, abs_b;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic               is_mult, neg_q, neg_r, sgn;

    assign sgn   = ~op[0];
    assign abs_a = (sgn && a[WIDTH-1]) ? neg_w(a) : a;
    assign abs_b = (sgn && b[WIDTH-1]) ? neg_w(b) : b;

    // Multiply: acc = {partial sum, remaining multiplier}; divide: acc = {remainder, quotient/dividend}.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, m};
        early  = 1'b0;
        if (is_mult)
            acc_nx = {sum, acc[WIDTH-1:1]};
        else if (!diff[WIDTH])
            acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nx = {acc[2*WIDTH-2:0], 1'b0};
`ifdef MULT_EARLY_TERM_EN
        if (is_mult && ((acc[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt)) == '0)) begin
            early  = 1'b1;
            acc_nx = acc >> cnt;
        end
`endif
    end

`ifndef MULT_EARLY_TERM_EN
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif

    always_comb begin
        prod_fix = neg_q ? neg_w2(acc) : acc;
        if (is_mult) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else begin
            hi_fix = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
            lo_fix = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            m       <= '0;
            is_mult <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (load) begin
                is_mult <= ~op[1];
                neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r   <= sgn & a[WIDTH-1];
                m       <= op[1] ? abs_b : abs_a;
                acc     <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            end else if (step) begin
                acc <= acc_nx;
            end
            if (finish) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
        end
    end

    // The fixed-up result is visible in the same cycle as done.
    assign hi = finish ? hi_fix : hi_q;
    assign lo = finish ? lo_fix : lo_q;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide engine: FSM, counter and start/busy/done handshake
// Optional MULT_EARLY_TERM_EN: variable multiply latency via early termination in the datapath.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             load, step, early;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                op_q <= op_t'(op);
                a_q  <= a;
                b_q  <= b;
            end
            if (load)
                cnt <= CNT_W'(WIDTH);
            else if (step)
                cnt <= early ? '0 : cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        div0     = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_LOAD;
            end
            S_LOAD: begin
                load = 1'b1;
                if (abort)
                    state_nx = S_IDLE;
                else if (op_q[1] && b_q == '0)
                    state_nx = S_DIVZERO;
                else
                    state_nx = S_CALC;
            end
            S_CALC: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (early || cnt == CNT_W'(1))
                        state_nx = S_RESULT;
                end
            end
            // abort wins over completion: no pulse and no hi/lo update.
            S_RESULT: begin
                done     = ~abort;
                state_nx = S_IDLE;
            end
            S_DIVZERO: begin
                div0     = ~abort;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    mult_div_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .cnt    (cnt),
        .load   (load),
        .step   (step),
        .finish (done),
        .early  (early),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - table-driven self-checking bench for mult_div_unit (WIDTH=32)
module tb_mult_div_unit;

`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clock, reset, start, abort;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int checks, errors;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          dc;
        int          zc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one op and watch it cycle by cycle; cycle 1 is the cycle after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int dc, output int zc, output int nd, output int nz,
                          output int bl, output logic b1,
                          output logic [31:0] dhi, output logic [31:0] dlo, output logic to);
        dc = -1; zc = -1; nd = 0; nz = 0; bl = 0; b1 = 1'b0; dhi = '0; dlo = '0; to = 1'b1;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 1) b1 = busy;
            if (busy) bl = c;
            if (done) begin nd++; dc = c; dhi = hi; dlo = lo; end
            if (div0) begin nz++; zc = c; end
            if (!busy) begin to = 1'b0; break; end
            @(negedge clock);
        end
    endtask

    initial begin
        int dc, zc, nd, nz, bl, seen_busy;
        logic b1, to;
        logic [31:0] dhi, dlo;
        string nm;

        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;

        tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, -1};
        tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, -1};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, -1};
        tbl[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 34, -1};
        tbl[4]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, -1, 2};
        tbl[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, -1};
        tbl[6]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34, -1};
        tbl[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, -1};
        tbl[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, -1};
        tbl[9]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h40000000, 32'h00000000, -1, 2};
        tbl[10] = '{2'b01, 32'h00000000, 32'h00003039, 32'h00000000, 32'h00000000, 34, -1};
        tbl[11] = '{2'b00, 32'h00000007, 32'h00000009, 32'h00000000, 32'h0000003F, 34, -1};

        #2 reset = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div0", div0, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, dc, zc, nd, nz, bl, b1, dhi, dlo, to);
            nm = $sformatf("v%0d", i);
            chk({nm, " timeout"}, to, 0);
            chk({nm, " busy@1"}, b1, 1);
            chk({nm, " done pulses"}, nd, (tbl[i].dc > 0) ? 1 : 0);
            chk({nm, " div0 pulses"}, nz, (tbl[i].zc > 0) ? 1 : 0);
            chk({nm, " div0 cycle"}, zc, tbl[i].zc);
            if (!(EARLY && !tbl[i].op[1])) begin
                chk({nm, " done cycle"}, dc, tbl[i].dc);
                chk({nm, " busy last"}, bl, (tbl[i].dc > 0) ? tbl[i].dc : tbl[i].zc);
            end
            if (tbl[i].dc > 0) begin
                chk({nm, " hi@done"}, dhi, tbl[i].hi);
                chk({nm, " lo@done"}, dlo, tbl[i].lo);
            end
            chk({nm, " hi"}, hi, tbl[i].hi);
            chk({nm, " lo"}, lo, tbl[i].lo);
        end

        // Re-start during CALC is ignored, then abort drops back to IDLE without a result.
        nd = 0; nz = 0; seen_busy = 0;
        @(negedge clock);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (done) nd++;
            if (div0) nz++;
            if (c == 5) begin start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; end
            if (c == 6) start = 1'b0;
            if (c == 10) begin chk("abort busy@10", busy, 1); abort = 1'b1; end
            if (c == 11) begin chk("abort busy@11", busy, 0); abort = 1'b0; end
            if (c < 11) @(negedge clock);
        end
        repeat (45) begin
            @(negedge clock);
            if (done) nd++;
            if (div0) nz++;
            if (busy) seen_busy++;
        end
        chk("abort done pulses", nd, 0);
        chk("abort div0 pulses", nz, 0);
        chk("abort no queued start", seen_busy, 0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h3F);

        // Async reset mid-CALC clears outputs without a clock edge.
        @(negedge clock);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        chk("pre-reset busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        chk("async reset hi", hi, 0);
        chk("async reset lo", lo, 0);
        @(negedge clock);
        reset = 1'b1;

        run_op(2'b11, 32'd100, 32'd7, dc, zc, nd, nz, bl, b1, dhi, dlo, to);
        chk("post-reset timeout", to, 0);
        chk("post-reset done cycle", dc, 34);
        chk("post-reset hi", dhi, 32'd2);
        chk("post-reset lo", dlo, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
